alu_decode_stage: RTL

Registered decode/issue stage directly upstream of the 32-bit ALU. It accepts an RV32I instruction plus register-file read data and produces the ALU op code, the two operands and the writeback destination. It uses a valid/ready handshake with a 2-entry skid buffer, so both ready and data outputs are registered. Integer ALU instructions only (OP, OP-IMM); every other opcode issues as a non-writing bubble.

---
 rtl/alu_decode_stage.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// RV32I integer decode/issue stage feeding the ALU, with registered valid/ready and a 2-entry skid buffer.
// Optional build macro ALU_DEC_ILLEGAL_EN adds an 'illegal' output and squashes malformed OP/OP-IMM encodings.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      op,
    output logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] rv2,
    output logic [4:0]      rd,
    output logic            we
`ifdef ALU_DEC_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    typedef struct packed {
        logic [5:0]      op;
        logic [XLEN-1:0] rv1;
        logic [XLEN-1:0] rv2;
        logic [4:0]      rd;
        logic            we;
`ifdef ALU_DEC_ILLEGAL_EN
        logic            illegal;
`endif
    } bundle_t;

    state_t  r_state;
    state_t  w_state_next;
    logic    r_in_ready;
    logic    r_out_valid;
    bundle_t r_main;
    bundle_t r_skid;
    bundle_t w_dec;

    logic       w_accept;
    logic       w_consume;
    logic       w_load_main_dec;
    logic       w_load_main_skid;
    logic       w_load_skid;
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_op;
    logic       w_is_op_imm;
    logic       w_is_shift_imm;
    logic       w_alt;
    logic       w_illegal;
    logic       w_unused_rs1_idx;

    assign w_opcode       = instr[6:0];
    assign w_funct3       = instr[14:12];
    assign w_funct7       = instr[31:25];
    assign w_is_op        = (w_opcode == OPC_OP);
    assign w_is_op_imm    = (w_opcode == OPC_OP_IMM);
    assign w_is_shift_imm = w_is_op_imm && (w_funct3 == 3'b001 || w_funct3 == 3'b101);
    // The rs1 index is consumed by the register file; rs1_data already carries its value.
    assign w_unused_rs1_idx = ^instr[19:15];

    assign w_alt = (w_is_op && (w_funct3 == 3'b000 || w_funct3 == 3'b101) && instr[30]) ||
                   (w_is_op_imm && (w_funct3 == 3'b101) && instr[30]);

`ifdef ALU_DEC_ILLEGAL_EN
    assign w_illegal =
        (w_is_op && !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000)) ||
        (w_is_op && (w_funct7 == 7'b0100000) && !(w_funct3 == 3'b000 || w_funct3 == 3'b101)) ||
        (w_is_op_imm && (w_funct3 == 3'b001) && (w_funct7 != 7'b0000000)) ||
        (w_is_op_imm && (w_funct3 == 3'b101) &&
            !(w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000));
`else
    assign w_illegal = 1'b0;
`endif

    always_comb begin
        // NOTE: every field gets a default first so no path through this block can infer a latch.
        w_dec    = '0;
        w_dec.rd = instr[11:7];
        if (w_is_op || w_is_op_imm) begin
            w_dec.op  = {1'b0, w_alt, 1'b1, w_funct3};
            w_dec.rv1 = rs1_data;
            if (w_is_op)
                w_dec.rv2 = rs2_data;
            else if (w_is_shift_imm)
                w_dec.rv2 = {{(XLEN-5){1'b0}}, instr[24:20]};
            else
                w_dec.rv2 = {{(XLEN-12){instr[31]}}, instr[31:20]};
            w_dec.we = (instr[11:7] != 5'd0);
        end
`ifdef ALU_DEC_ILLEGAL_EN
        w_dec.illegal = w_illegal;
        if (w_illegal) begin
            w_dec.op = 6'd0;
            w_dec.we = 1'b0;
        end
`endif
    end

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_dec  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_main_dec = 1'b1;
                    w_state_next    = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main_dec = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_state_next = S_FULL;
                end else if (w_consume) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_consume) begin
                    w_load_main_skid = 1'b1;
                    w_state_next     = S_ONE;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the bundle registers are reset too, because the outputs must read zero out of reset.
        if (reset) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != S_FULL);
            r_out_valid <= (w_state_next != S_EMPTY);
            if (w_load_main_dec)
                r_main <= w_dec;
            else if (w_load_main_skid)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= w_dec;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign op        = r_main.op;
    assign rv1       = r_main.rv1;
    assign rv2       = r_main.rv2;
    assign rd        = r_main.rd;
    assign we        = r_main.we;
`ifdef ALU_DEC_ILLEGAL_EN
    assign illegal   = r_main.illegal;
`endif

endmodule
